// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin sharing of an HD44780 LCD bus between two writers with strobe and busy-wait timing
module lcd_bus_arbiter #(
  parameter int EN_SETUP = 2,
  parameter int EN_HIGH  = 25,
  parameter int EN_HOLD  = 2,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] dat0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] dat1,
  output logic       ack1,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, DONE} state_t;
  localparam int M1 = (EN_SETUP > EN_HIGH) ? EN_SETUP : EN_HIGH;
  localparam int M2 = (M1 > EN_HOLD) ? M1 : EN_HOLD;
  localparam int M3 = (M2 > CMD_WAIT) ? M2 : CMD_WAIT;
  localparam int MAXV = (M3 > CLR_WAIT) ? M3 : CLR_WAIT;
  localparam int CW = $clog2(MAXV + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, wait_len;
  logic last, pick, clr;
  // last also names the writer currently holding the bus
  assign pick = (req0 & req1) ? ~last : req1;
  assign clr = ~lcd_rs & (lcd_data inside {8'h01, 8'h02, 8'h03});
  assign wait_len = clr ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
  assign lcd_rw = 1'b0;
  assign lcd_en = state == PULSE;
  assign busy = state != IDLE;
  assign ack0 = (state == DONE) & ~last;
  assign ack1 = (state == DONE) & last;
  always_comb begin
    state_nxt = state;
    cnt_nxt = (cnt == '0) ? cnt : cnt - CW'(1);
    case (state)
      IDLE: if (req0 | req1) begin
        state_nxt = SETUP;
        cnt_nxt = CW'(EN_SETUP - 1);
      end
      SETUP: if (cnt == '0) begin
        state_nxt = PULSE;
        cnt_nxt = CW'(EN_HIGH - 1);
      end
      PULSE: if (cnt == '0) begin
        state_nxt = HOLD;
        cnt_nxt = CW'(EN_HOLD - 1);
      end
      HOLD: if (cnt == '0) begin
        state_nxt = WAIT;
        cnt_nxt = wait_len;
      end
      WAIT: state_nxt = (cnt == '0) ? DONE : WAIT;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      lcd_rs <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (state == IDLE && (req0 | req1)) begin
        last <= pick;
        lcd_rs <= pick ? rs1 : rs0;
        lcd_data <= pick ? dat1 : dat0;
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed vector table plus hand-written contention and reset sequences
module tb_lcd_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
  logic ack0, ack1, lcd_rs, lcd_rw, lcd_en, busy;
  logic [7:0] lcd_data;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    bit w;
    bit rs;
    logic [7:0] dat;
    bit drop;
    int exp;
  } vec_t;
  vec_t vecs[7];
  lcd_bus_arbiter #(.EN_SETUP(2), .EN_HIGH(4), .EN_HOLD(2), .CMD_WAIT(8), .CLR_WAIT(20)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rs0(rs0), .dat0(dat0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .dat1(dat1), .ack1(ack1),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // every wait goes through here so the bus invariants are checked each cycle
  task automatic tick();
    @(negedge clk);
    chk("rw_zero", 32'(lcd_rw), 0);
    chk("ack_excl", 32'(ack0 & ack1), 0);
    chk("en_only_busy", 32'(lcd_en & ~busy), 0);
  endtask
  task automatic xfer(input vec_t v);
    int en_first = 0, en_last = 0, ack_at = 0, ack_n = 0, other_n = 0;
    if (v.w) begin req1 = 1'b1; rs1 = v.rs; dat1 = v.dat; end
    else begin req0 = 1'b1; rs0 = v.rs; dat0 = v.dat; end
    for (int k = 1; k <= v.exp + 3; k++) begin
      tick();
      if (k == 1) begin
        chk("busy_grant", 32'(busy), 1);
        chk("rs_grant", 32'(lcd_rs), 32'(v.rs));
        chk("data_grant", 32'(lcd_data), 32'(v.dat));
        if (v.drop) begin
          if (v.w) begin req1 = 1'b0; dat1 = 8'hFF; end
          else begin req0 = 1'b0; dat0 = 8'hFF; end
        end
      end
      if (lcd_en) begin
        if (en_first == 0) en_first = k;
        en_last = k;
      end
      if (v.w ? ack1 : ack0) begin
        ack_at = k;
        ack_n++;
        if (v.w) req1 = 1'b0; else req0 = 1'b0;
      end
      if (v.w ? ack0 : ack1) other_n++;
    end
    chk("en_first", 32'(en_first), 3);
    chk("en_last", 32'(en_last), 6);
    chk("ack_cycle", 32'(ack_at), 32'(v.exp));
    chk("ack_once", 32'(ack_n), 1);
    chk("other_ack", 32'(other_n), 0);
    chk("busy_end", 32'(busy), 0);
    chk("data_held", 32'(lcd_data), 32'(v.dat));
    chk("rs_held", 32'(lcd_rs), 32'(v.rs));
  endtask
  initial begin
    int n;
    vecs[0] = '{w: 1'b0, rs: 1'b1, dat: 8'h41, drop: 1'b0, exp: 17};
    vecs[1] = '{w: 1'b1, rs: 1'b0, dat: 8'h01, drop: 1'b0, exp: 29};
    vecs[2] = '{w: 1'b1, rs: 1'b0, dat: 8'h03, drop: 1'b0, exp: 29};
    vecs[3] = '{w: 1'b1, rs: 1'b1, dat: 8'h01, drop: 1'b0, exp: 17};
    vecs[4] = '{w: 1'b0, rs: 1'b0, dat: 8'h02, drop: 1'b0, exp: 29};
    vecs[5] = '{w: 1'b1, rs: 1'b0, dat: 8'h04, drop: 1'b0, exp: 17};
    vecs[6] = '{w: 1'b0, rs: 1'b1, dat: 8'hA5, drop: 1'b1, exp: 17};
    tick();
    tick();
    chk("rst_en", 32'(lcd_en), 0);
    chk("rst_rs", 32'(lcd_rs), 0);
    chk("rst_data", 32'(lcd_data), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);
    foreach (vecs[i]) xfer(vecs[i]);
    rst = 1'b1;
    req0 = 1'b1; rs0 = 1'b1; dat0 = 8'hA0;
    req1 = 1'b1; rs1 = 1'b1; dat1 = 8'hB1;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 120 && n < 4; c++) begin
      tick();
      if (ack0 | ack1) begin
        chk("alt_writer", 32'(ack1), 32'(n % 2));
        chk("alt_data", 32'(lcd_data), (n % 2) ? 32'hB1 : 32'hA0);
        n++;
      end
    end
    chk("alt_count", 32'(n), 4);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int c = 0; c < 40 && busy; c++) tick();
    chk("alt_idle", 32'(busy), 0);
    req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h55;
    for (int k = 1; k <= 4; k++) tick();
    chk("pre_rst_en", 32'(lcd_en), 1);
    rst = 1'b1;
    req0 = 1'b1; rs0 = 1'b0; dat0 = 8'h3C;
    tick();
    chk("mid_rst_en", 32'(lcd_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", 32'(lcd_data), 0);
    chk("mid_rst_ack1", 32'(ack1), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 1);
    chk("post_rst_data", 32'(lcd_data), 32'h3C);
    chk("post_rst_rs", 32'(lcd_rs), 0);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
